// File: rtl/linear_pkg.sv
// ============================================================================
// Module  : linear_pkg
// Brief   : Shared types, state encoding and saturation helper for linear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package linear_pkg;

    typedef logic signed [15:0] q8_8_t;
    typedef logic        [7:0]  q0_8_t;
    typedef logic signed [31:0] acc_t;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_LOAD   = 3'd0;
    localparam state_t c_ST_ARG    = 3'd1;
    localparam state_t c_ST_DELTA  = 3'd2;
    localparam state_t c_ST_ERR    = 3'd3;
    localparam state_t c_ST_UPDATE = 3'd4;

    localparam acc_t c_Q_MAX = 32'sd32767;
    localparam acc_t c_Q_MIN = -32'sd32768;

    function automatic q8_8_t sat16(input acc_t v);
        if (v > c_Q_MAX) begin
            return 16'sh7fff;
        end else if (v < c_Q_MIN) begin
            return 16'sh8000;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/linear_weight_bank.sv
// ============================================================================
// Module  : weight_bank
// Brief   : N weights plus bias (entry N); combinational read, saturating RMW.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_bank
    import linear_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] rd_index,
    output q8_8_t         rd_data,
    output q8_8_t         bias,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_index,
    input  acc_t          upd_addend
);

    q8_8_t r_mem [N+1];

    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= N; i++) begin
            if (rd_index == IW'(i)) begin
                rd_data = r_mem[i];
            end
        end
    end

    assign bias = r_mem[N];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (upd_en) begin
            for (int i = 0; i <= N; i++) begin
                if (upd_index == IW'(i)) begin
                    r_mem[i] <= sat16(acc_t'(r_mem[i]) + upd_addend);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/linear.sv
// ============================================================================
// Module  : linear
// Brief   : Trainable single-neuron weighted sum, Q0.8 inputs -> Q8.8 argument.
//           Optional macro LINEAR_ERROR_EN adds the back-propagated error port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module linear
    import linear_pkg::*;
#(
    parameter int N          = 4,
    parameter int RATE_SHIFT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        train,
    input  logic        input_valid,
    input  logic [7:0]  input_data,
    output logic        input_ready,
    output logic        argument_valid,
    output logic [15:0] argument_data,
    input  logic        argument_ready,
    input  logic        delta_valid,
    input  logic [15:0] delta_data,
    output logic        delta_ready
`ifdef LINEAR_ERROR_EN
    ,
    output logic        error_valid,
    output logic [15:0] error_data,
    input  logic        error_ready
`endif
);

    localparam int                c_IW       = $clog2(N + 1);
    localparam logic [c_IW-1:0]   c_IDX_LAST = c_IW'(N - 1);
    localparam logic [c_IW-1:0]   c_IDX_BIAS = c_IW'(N);

    state_t            r_state;
    logic [c_IW-1:0]   r_index;
    acc_t              r_acc;
    q0_8_t             r_x [N];
    q8_8_t             r_delta;
    logic              r_arg_valid;
    q8_8_t             r_arg_data;

    q8_8_t             w_rd_data;
    q8_8_t             w_bias;
    q0_8_t             w_x_sel;
    acc_t              w_acc_next;
    acc_t              w_upd_addend;
    logic              w_upd_en;

    weight_bank #(
        .N  (N),
        .IW (c_IW)
    ) u_weight_bank (
        .clock      (clock),
        .reset      (reset),
        .rd_index   (r_index),
        .rd_data    (w_rd_data),
        .bias       (w_bias),
        .upd_en     (w_upd_en),
        .upd_index  (r_index),
        .upd_addend (w_upd_addend)
    );

    always_comb begin
        w_x_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (r_index == c_IW'(i)) begin
                w_x_sel = r_x[i];
            end
        end
    end

    // The first product of a vector starts from the bias aligned to Q16.16.
    assign w_acc_next = ((r_index == '0) ? (acc_t'(w_bias) <<< 8) : r_acc)
                      + acc_t'(w_rd_data) * acc_t'($signed({1'b0, input_data}));

    assign w_upd_en     = (r_state == c_ST_UPDATE);
    assign w_upd_addend = (r_index == c_IDX_BIAS)
                        ? (acc_t'(r_delta) >>> RATE_SHIFT)
                        : ((acc_t'(r_delta) * acc_t'($signed({1'b0, w_x_sel}))) >>> (8 + RATE_SHIFT));

    assign input_ready    = (r_state == c_ST_LOAD);
    assign delta_ready    = (r_state == c_ST_DELTA);
    assign argument_valid = r_arg_valid;
    assign argument_data  = r_arg_data;

`ifdef LINEAR_ERROR_EN
    q8_8_t w_err_data;
    // ERR runs before UPDATE, so the read port still returns the old weight.
    assign w_err_data  = sat16((acc_t'(w_rd_data) * acc_t'(r_delta)) >>> 8);
    assign error_valid = (r_state == c_ST_ERR);
    assign error_data  = (r_state == c_ST_ERR) ? w_err_data : '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_LOAD;
            r_index     <= '0;
            r_acc       <= '0;
            r_delta     <= '0;
            r_arg_valid <= 1'b0;
            r_arg_data  <= '0;
            for (int i = 0; i < N; i++) begin
                r_x[i] <= '0;
            end
        end else begin
            case (r_state)
                c_ST_LOAD: begin
                    if (input_valid) begin
                        for (int i = 0; i < N; i++) begin
                            if (r_index == c_IW'(i)) begin
                                r_x[i] <= input_data;
                            end
                        end
                        r_acc <= w_acc_next;
                        if (r_index == c_IDX_LAST) begin
                            r_state     <= c_ST_ARG;
                            r_index     <= '0;
                            r_arg_valid <= 1'b1;
                            r_arg_data  <= sat16(w_acc_next >>> 8);
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                c_ST_ARG: begin
                    if (argument_ready) begin
                        r_arg_valid <= 1'b0;
                        r_state     <= train ? c_ST_DELTA : c_ST_LOAD;
                    end
                end
                c_ST_DELTA: begin
                    if (delta_valid) begin
                        r_delta <= delta_data;
                        r_index <= '0;
`ifdef LINEAR_ERROR_EN
                        r_state <= c_ST_ERR;
`else
                        r_state <= c_ST_UPDATE;
`endif
                    end
                end
`ifdef LINEAR_ERROR_EN
                c_ST_ERR: begin
                    if (error_ready) begin
                        if (r_index == c_IDX_LAST) begin
                            r_state <= c_ST_UPDATE;
                            r_index <= '0;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
`endif
                c_ST_UPDATE: begin
                    if (r_index == c_IDX_BIAS) begin
                        r_state <= c_ST_LOAD;
                        r_index <= '0;
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_LOAD;
                    r_index <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_linear.sv
// ============================================================================
// Module  : tb_linear
// Brief   : Scoreboard bench for linear against an arithmetic neuron model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_linear;

    localparam int N     = 2;
    localparam int RS    = 0;
    localparam int LIMIT = 2000;

    typedef logic [7:0] vec_t [N];

    logic        clock;
    logic        reset;
    logic        train;
    logic        input_valid;
    logic [7:0]  input_data;
    logic        input_ready;
    logic        argument_valid;
    logic [15:0] argument_data;
    logic        argument_ready;
    logic        delta_valid;
    logic [15:0] delta_data;
    logic        delta_ready;
`ifdef LINEAR_ERROR_EN
    logic        error_valid;
    logic [15:0] error_data;
    logic        error_ready;
`endif

    linear #(
        .N          (N),
        .RATE_SHIFT (RS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .train          (train),
        .input_valid    (input_valid),
        .input_data     (input_data),
        .input_ready    (input_ready),
        .argument_valid (argument_valid),
        .argument_data  (argument_data),
        .argument_ready (argument_ready),
        .delta_valid    (delta_valid),
        .delta_data     (delta_data),
        .delta_ready    (delta_ready)
`ifdef LINEAR_ERROR_EN
        ,
        .error_valid    (error_valid),
        .error_data     (error_data),
        .error_ready    (error_ready)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int w_m [N];
    int bias_m;
    int q_arg [$];
    int q_err [$];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic abort(input string what);
        checks++;
        failures++;
        $display("FAIL timeout_%s actual=no_handshake expected=handshake_within_%0d_cycles", what, LIMIT);
        finish_run();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return input_ready;
            1:       return argument_valid;
            default: return delta_ready;
        endcase
    endfunction

    task automatic wait_high(input int which, input string what);
        int t = 0;
        @(negedge clock);
        while (!sel(which)) begin
            t++;
            if (t > LIMIT) abort(what);
            @(negedge clock);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) w_m[i] = 0;
        bias_m = 0;
        q_arg.delete();
        q_err.delete();
    endtask

    function automatic int model_fwd(input vec_t x);
        int acc = bias_m * 256;
        for (int i = 0; i < N; i++) acc += w_m[i] * int'(x[i]);
        return sat(acc >>> 8);
    endfunction

    task automatic model_train(input vec_t x, input int d);
`ifdef LINEAR_ERROR_EN
        for (int i = 0; i < N; i++) q_err.push_back(sat((w_m[i] * d) >>> 8));
`endif
        for (int i = 0; i < N; i++) w_m[i] = sat(w_m[i] + ((d * int'(x[i])) >>> (8 + RS)));
        bias_m = sat(bias_m + (d >>> RS));
    endtask

    task automatic hs_input(input logic [7:0] x, input int stall);
        repeat (stall) tick();
        input_valid = 1'b1;
        input_data  = x;
        wait_high(0, "input");
        tick();
        input_valid = 1'b0;
        input_data  = 8'($urandom);
    endtask

    task automatic run_vector(input vec_t x, input logic do_train, input int d,
                              input int arg_stall, input int delta_stall);
        q_arg.push_back(model_fwd(x));
        for (int i = 0; i < N; i++) begin
            train = 1'($urandom_range(0, 1));
            hs_input(x[i], $urandom_range(0, 2));
        end
        check("arg_latency", int'(argument_valid), 1);
        repeat (arg_stall) begin
            train = 1'($urandom_range(0, 1));
            tick();
        end
        train          = do_train;
        argument_ready = 1'b1;
        wait_high(1, "argument");
        tick();
        argument_ready = 1'b0;
        train          = 1'($urandom_range(0, 1));
        check("arg_drop", int'(argument_valid), 0);
        if (do_train) begin
            repeat (delta_stall) tick();
            model_train(x, d);
            delta_valid = 1'b1;
            delta_data  = 16'(d);
            wait_high(2, "delta");
            tick();
            delta_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_arg_valid"}, int'(argument_valid), 0);
        check({tag, "_arg_data"}, int'(argument_data), 0);
        check({tag, "_delta_ready"}, int'(delta_ready), 0);
`ifdef LINEAR_ERROR_EN
        check({tag, "_err_valid"}, int'(error_valid), 0);
        check({tag, "_err_data"}, int'(error_data), 0);
`endif
    endtask

    // Monitor: pops expected arguments on handshakes and checks stall stability.
    initial begin
        logic        hold;
        logic [15:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            if (!reset || !argument_valid) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("arg_hold", int'(argument_data), int'(held));
                    check("input_ready_in_arg", int'(input_ready), 0);
                end
                if (argument_ready) begin
                    if (q_arg.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL arg_unexpected actual=%0d expected=none", $signed(argument_data));
                    end else begin
                        check("argument_data", int'($signed(argument_data)), q_arg.pop_front());
                    end
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    held = argument_data;
                end
            end
        end
    end

`ifdef LINEAR_ERROR_EN
    initial begin
        error_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            error_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (reset && error_valid && error_ready) begin
                if (q_err.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_unexpected actual=%0d expected=none", $signed(error_data));
                end else begin
                    check("error_data", int'($signed(error_data)), q_err.pop_front());
                end
            end
        end
    end
`endif

    initial begin
        #5000000;
        abort("global");
    end

    initial begin
        vec_t v;
        reset          = 1'b0;
        train          = 1'b0;
        input_valid    = 1'b0;
        input_data     = '0;
        argument_ready = 1'b0;
        delta_valid    = 1'b0;
        delta_data     = '0;
        model_clear();
        tick();
        check_reset_outputs("rst");
        check("rst_input_ready", int'(input_ready), 1);
        tick();
        reset = 1'b1;
        tick();

        // Forward with zero weights.
        v[0] = 8'd128; v[1] = 8'd255;
        run_vector(v, 1'b0, 0, 0, 0);
        check("load_after_fwd", int'(input_ready), 1);

        // Training step then forward.
        v[0] = 8'd128; v[1] = 8'd128;
        run_vector(v, 1'b1, 256, 0, 0);
        v[0] = 8'd128; v[1] = 8'd255;
        run_vector(v, 1'b0, 0, 0, 0);

        // Backpressure on argument and withheld delta.
        run_vector(v, 1'b1, -300, 10, 5);
        run_vector(v, 1'b0, 0, 3, 0);

        // Saturation.
        reset = 1'b0; model_clear(); tick(); reset = 1'b1; tick();
        v[0] = 8'd255; v[1] = 8'd255;
        run_vector(v, 1'b1, 32767, 0, 0);
        run_vector(v, 1'b1, 32767, 0, 0);
        run_vector(v, 1'b0, 0, 0, 0);

        // Error back-propagation scenario (errors checked only when enabled).
        reset = 1'b0; model_clear(); tick(); reset = 1'b1; tick();
        v[0] = 8'd128; v[1] = 8'd128;
        run_vector(v, 1'b1, 256, 0, 0);
        run_vector(v, 1'b1, -512, 0, 0);
        run_vector(v, 1'b0, 0, 0, 0);

        // Async reset mid-LOAD.
        hs_input(8'd77, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid_load");
        model_clear();
        tick();
        reset = 1'b1;
        tick();
        v[0] = 8'd0; v[1] = 8'd0;
        run_vector(v, 1'b0, 0, 0, 0);

        // Async reset mid-UPDATE, after training some nonzero weights.
        v[0] = 8'd200; v[1] = 8'd100;
        run_vector(v, 1'b1, 1000, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_mid_update");
        model_clear();
        tick();
        reset = 1'b1;
        tick();
        v[0] = 8'd0; v[1] = 8'd0;
        run_vector(v, 1'b0, 0, 0, 0);
        v[0] = 8'd255; v[1] = 8'd255;
        run_vector(v, 1'b0, 0, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < N; i++) v[i] = 8'($urandom_range(0, 255));
            run_vector(v, 1'($urandom_range(0, 1)), $urandom_range(0, 65535) - 32768,
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (60) tick();
        check("arg_queue_empty", q_arg.size(), 0);
        check("err_queue_empty", q_err.size(), 0);
        finish_run();
    end

endmodule

`default_nettype wire
